// File: rtl/mem_init_pkg.sv
// Shared types and constants for the byte-serial load/store initiator.
// Optional misalignment trapping in the top is enabled by MEM_INIT_MISALIGN_CHECK_EN.
package mem_init_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } init_state_t;

  localparam logic [2:0] BYTES_BYTE = 3'd1;
  localparam logic [2:0] BYTES_HALF = 3'd2;
  localparam logic [2:0] BYTES_WORD = 3'd4;

  // The reserved size encoding 3 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    decode_size = MEM_BYTE;
      2'd1:    decode_size = MEM_HALF;
      default: decode_size = MEM_WORD;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input mem_size_t size);
    case (size)
      MEM_BYTE: size_bytes = BYTES_BYTE;
      MEM_HALF: size_bytes = BYTES_HALF;
      default:  size_bytes = BYTES_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load data; purely combinational.
module load_extend
  import mem_init_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  mem_size_t             size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] ext
);

  localparam int unsigned HalfWidth = 2 * BYTE_WIDTH;

  logic byte_sign;
  logic half_sign;

  assign byte_sign = raw[BYTE_WIDTH-1] & ~is_unsigned;
  assign half_sign = raw[HalfWidth-1] & ~is_unsigned;

  // Pick the extension matching the access size; word data passes through untouched.
  always_comb begin
    ext = raw;
    case (size)
      MEM_BYTE: ext = {{(DATA_WIDTH-BYTE_WIDTH){byte_sign}}, raw[BYTE_WIDTH-1:0]};
      MEM_HALF: ext = {{(DATA_WIDTH-HalfWidth){half_sign}}, raw[HalfWidth-1:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_byte_initiator.sv
// Load/store initiator: serialises one byte/half/word request into little-endian byte
// accesses, one per cycle, and returns a single-cycle response.
// Define MEM_INIT_MISALIGN_CHECK_EN to answer misaligned half/word requests with an error
// instead of executing them bytewise.
module mem_byte_initiator
  import mem_init_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int unsigned NumLanes = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned IdxW     = $clog2(NumLanes);

  init_state_t           state_q, state_d;
  logic                  we_q;
  mem_size_t             size_q;
  logic                  uns_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [IdxW-1:0]       k_q;
  logic [IdxW-1:0]       last_q;

  logic                  hs;
  mem_size_t             req_sz;
  logic                  misaligned;
  logic                  last_byte;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [BYTE_WIDTH-1:0] wr_byte;
  logic                  unused_rd;

  assign hs        = req_valid & (state_q == IDLE);
  assign req_sz    = decode_size(req_size);
  assign last_byte = (k_q == last_q);
  assign wr_byte   = wdata_q[k_q*BYTE_WIDTH +: BYTE_WIDTH];
  assign unused_rd = ^mem_rd[DATA_WIDTH-1:BYTE_WIDTH];

`ifdef MEM_INIT_MISALIGN_CHECK_EN
  assign misaligned = ((req_sz == MEM_HALF) && req_addr[0]) ||
                      ((req_sz == MEM_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: misaligned requests skip ACCESS entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) state_d = misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        if (last_byte) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on req_* directly.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_we   = we_q;
        mem_addr = addr_q + DATA_WIDTH'(k_q);
        mem_wd   = we_q ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, wr_byte} : '0;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = (we_q || err_q) ? '0 : ext_data;
      end
      default: ;
    endcase
  end

`ifdef MEM_INIT_MISALIGN_CHECK_EN
  assign resp_err = (state_q == RESP) & err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Request capture, byte index and load assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= MEM_BYTE;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      k_q     <= '0;
      last_q  <= '0;
    end else if (hs) begin
      we_q    <= req_we;
      size_q  <= req_sz;
      uns_q   <= req_unsigned;
      err_q   <= misaligned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      k_q     <= '0;
      last_q  <= IdxW'(size_bytes(req_sz) - 3'd1);
    end else if (state_q == ACCESS) begin
      if (!we_q) rdata_q[k_q*BYTE_WIDTH +: BYTE_WIDTH] <= mem_rd[BYTE_WIDTH-1:0];
      if (!last_byte) k_q <= k_q + 1'b1;
    end
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_load_extend (
    .raw        (rdata_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .ext        (ext_data)
  );

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Directed bench for mem_byte_initiator with a 16-byte aliased memory model.
module tb_mem_byte_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [7:0]  mem [16];
  int          n_err = 0;
  int          n_chk = 0;
  int          wr_cnt = 0;
  int          wr_base;

  always #5 clk = ~clk;

  always_comb mem_rd = {24'h0, mem[mem_addr[3:0]]};

  always @(posedge clk) if (mem_we) wr_cnt <= wr_cnt + 1;

  mem_byte_initiator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  // Handshake at the next edge; returns #1 into cycle 1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    drive(we, size, uns, addr, wdata);
    chk("hs_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [7:0] data);
    chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_wd"}, mem_wd, {24'h0, data});
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rdata, input logic err);
    chk({tag, "_rv"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, rdata);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, err});
    chk({tag, "_mwe"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
  endtask

  // Full transaction: n byte accesses at addr+k, response, then ready again.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int n, input logic [31:0] exp_rdata);
    logic [31:0] wd;
    wd = wdata;
    issue(we, size, uns, addr, wdata);
    for (int k = 0; k < n; k++) begin
      check_access(tag, we, addr + k, we ? wd[8*k +: 8] : 8'h00);
      tick();
    end
    check_resp(tag, exp_rdata, 1'b0);
    tick();
    chk({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_idle_rv"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    tick();
    tick();

    // Reset values
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rv", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mwe", {31'b0, mem_we}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mwd", mem_wd, 32'd0);
    rst_n = 1'b1;
    tick();

    // Store word, bytes EF BE AD DE at 0x1000..0x1003
    run_req("st_word", 1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4, 32'h0);

    // Store byte and half; size 3 behaves as word
    run_req("st_byte", 1'b1, 2'd0, 1'b0, 32'h0000_2000, 32'h1234_56A5, 1, 32'h0);
    run_req("st_half", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_C3D4, 2, 32'h0);
    run_req("st_sz3", 1'b1, 2'd3, 1'b0, 32'h0000_2004, 32'h1122_3344, 4, 32'h0);

    // Byte loads, signed and unsigned
    mem[4] = 8'h80;
    run_req("lb", 1'b0, 2'd0, 1'b0, 32'h0000_1004, 32'h0, 1, 32'hFFFF_FF80);
    run_req("lbu", 1'b0, 2'd0, 1'b1, 32'h0000_1004, 32'h0, 1, 32'h0000_0080);
    mem[4] = 8'h7F;
    run_req("lb_pos", 1'b0, 2'd0, 1'b0, 32'h0000_1004, 32'h0, 1, 32'h0000_007F);

    // Half loads
    mem[6] = 8'h34;
    mem[7] = 8'hF2;
    run_req("lh", 1'b0, 2'd1, 1'b0, 32'h0000_1006, 32'h0, 2, 32'hFFFF_F234);
    run_req("lhu", 1'b0, 2'd1, 1'b1, 32'h0000_1006, 32'h0, 2, 32'h0000_F234);

    // Word load wrapping the address space; unsigned flag has no effect on words
    mem[14] = 8'h11;
    mem[15] = 8'h22;
    mem[0]  = 8'h33;
    mem[1]  = 8'h84;
    run_req("lw_wrap", 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, 32'h0, 4, 32'h8433_2211);

    // Misaligned word load
    mem[2] = 8'hAA;
    mem[3] = 8'hBB;
    mem[4] = 8'h80;
    mem[5] = 8'hCC;
`ifdef MEM_INIT_MISALIGN_CHECK_EN
    wr_base = wr_cnt;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0);
    check_resp("lw_mis", 32'h0, 1'b1);
    chk("lw_mis_mwd", mem_wd, 32'h0);
    tick();
    chk("lw_mis_ready", {31'b0, req_ready}, 32'd1);
    chk("lw_mis_rv_off", {31'b0, resp_valid}, 32'd0);
    chk("lw_mis_err_off", {31'b0, resp_err}, 32'd0);
`else
    run_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'h0, 4, 32'hCC80_BBAA);
`endif

    // Reset during cycle 3 of a word store: two bytes written, no response
    wr_base = wr_cnt;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
    check_access("st_rst_c1", 1'b1, 32'h0000_1000, 8'hEF);
    tick();
    check_access("st_rst_c2", 1'b1, 32'h0000_1001, 8'hBE);
    tick();
    check_access("st_rst_c3", 1'b1, 32'h0000_1002, 8'hAD);
    rst_n = 1'b0;
    #1;
    chk("st_rst_mwe", {31'b0, mem_we}, 32'd0);
    chk("st_rst_maddr", mem_addr, 32'd0);
    chk("st_rst_mwd", mem_wd, 32'd0);
    chk("st_rst_ready", {31'b0, req_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("st_rst_no_rv", {31'b0, resp_valid}, 32'd0);
      chk("st_rst_no_we", {31'b0, mem_we}, 32'd0);
      tick();
    end
    chk("st_rst_writes", wr_cnt - wr_base, 32'd2);

    // Back-to-back half loads with req_valid held high: second accepted at edge n+2 = 4
    mem[6] = 8'h34;
    mem[7] = 8'hF2;
    drive(1'b0, 2'd1, 1'b0, 32'h0000_1006, 32'h0);
    chk("b2b_ready0", {31'b0, req_ready}, 32'd1);
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk("b2b_busy", {31'b0, req_ready}, 32'd0);
      if (c == 3) check_resp("b2b_first", 32'hFFFF_F234, 1'b0);
      tick();
    end
    chk("b2b_ready_again", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check_access("b2b_second_k0", 1'b0, 32'h0000_1006, 8'h00);
    tick();
    check_access("b2b_second_k1", 1'b0, 32'h0000_1007, 8'h00);
    tick();
    check_resp("b2b_second", 32'hFFFF_F234, 1'b0);
    tick();
    chk("b2b_end_ready", {31'b0, req_ready}, 32'd1);
    chk("b2b_end_rv", {31'b0, resp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
